ceres_pbus_bridge: RTL and testbench
====================================

// Module: ceres_pbus_bridge
// PURPOSE
//  Bridges the CPU uncached iomem port to an APB-style peripheral bus (UART, SPI, I2C, GPIO, PWM, Timer, PLIC).
//  Occupies 0x2000_0000 region; slot = addr[15:12] (0x2000_0xxx slave0 ... 0x2000_7xxx slave7).
//  Single outstanding transfer, 32-bit data, returns one-cycle response pulse with error flag.
// PARAMETERS
//  NUM_SLAVES     8    number of PSEL lines (1..16); slots >= NUM_SLAVES decode as error
//  PADDR_W        12   width of paddr_o (in-slot byte offset)
//  TIMEOUT_CYCLES 255  max ACCESS cycles waiting for pready (only with CERES_PBUS_TIMEOUT_EN)
// PORTS
//  clk_i        in   1              system clock
//  rst_i        in   1              synchronous reset, active-high
//  req_valid_i  in   1              request valid; held stable until res_valid_o
//  req_sel_i    in   1              address decoder hit for peripheral region
//  req_addr_i   in   32             byte address
//  req_wdata_i  in   32             write data
//  req_wstrb_i  in   4              byte strobes; 0 = read
//  res_valid_o  out  1              one-cycle response pulse
//  res_rdata_o  out  32             read data (0 on write or error)
//  res_err_o    out  1              decode error, pslverr or timeout; qualified by res_valid_o
//  busy_o       out  1              state != IDLE
//  psel_o       out  NUM_SLAVES     one-hot slave select
//  penable_o    out  1              APB access phase
//  pwrite_o     out  1              1 = write
//  paddr_o      out  PADDR_W        req_addr_i[PADDR_W-1:0], word aligned ([1:0]=0)
//  pwdata_o     out  32             registered write data
//  pstrb_o      out  4              registered strobes
//  prdata_i     in   NUM_SLAVES*32  per-slave read data, slave n at [32n+:32]
//  pready_i     in   NUM_SLAVES     per-slave ready
//  pslverr_i    in   NUM_SLAVES     per-slave error
// BEHAVIOUR
//  Reset (sync, rst_i=1 at posedge): state=IDLE; all outputs 0; counter 0. Reset mid-transfer aborts, no response.
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; ERR path IDLE -> RESP.
//  IDLE: on req_valid_i & req_sel_i, latch addr/wdata/wstrb/slot; slot<NUM_SLAVES -> SETUP, else -> RESP with err=1.
//  SETUP (1 cycle): psel_o[slot]=1, penable_o=0, pwrite_o=|wstrb, paddr/pwdata/pstrb driven from latches.
//  ACCESS: psel_o[slot]=1, penable_o=1; on pready_i[slot]: capture prdata_i[slot] (reads only) and pslverr_i[slot] -> RESP.
//  RESP (1 cycle): res_valid_o=1, res_rdata_o/res_err_o from capture; psel/penable=0; -> IDLE.
//  Min latency: request seen in cycle 0 -> res_valid_o in cycle 3 (zero-wait slave); +1 cycle per pready wait state.
//  Decode error latency: res_valid_o in cycle 1, rdata=0, err=1; no PSEL asserted.
//  Requester drops req_valid_i the cycle after res_valid_o; IDLE accepts a new request next cycle (back-to-back: 4-cycle period).
//  req_valid_i outside IDLE ignored; latched values never change mid-transfer.
//  Write response: res_rdata_o=0; err=pslverr.
//  pready_i/pslverr_i of unselected slaves ignored; pslverr sampled only with pready.
// CONFIGURATION
//  CERES_PBUS_TIMEOUT_EN defined: 8-bit-min counter cleared on SETUP, increments each ACCESS cycle without pready;
//   when count reaches TIMEOUT_CYCLES with pready still low -> RESP, err=1, rdata=0; psel/penable dropped. pready in the
//   same cycle as the limit wins (normal completion).
//  Undefined: no counter; ACCESS waits indefinitely for pready.
// TESTING
//  Read slot1 addr 0x2000_1004, pready same cycle, prdata=0xA5A5_0001 -> psel=0b10, paddr=0x004, res_valid cycle 3, rdata=0xA5A5_0001, err=0.
//  Write 0x2000_0000 data 0x55 wstrb 0x1, pready after 2 waits -> pwrite=1, pstrb=0x1, res_valid cycle 5, err=0.
//  Access 0x2000_9000 (slot 9, NUM_SLAVES=8) -> no psel, res_valid cycle 1, err=1, rdata=0.
//  Read slot2, pready with pslverr=1 -> res_err=1, res_valid single pulse.
//  CERES_PBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready never -> err=1 after 4 ACCESS cycles; without macro busy_o stays 1.
//  rst_i asserted in ACCESS -> next cycle psel/penable/busy=0, no res_valid; next request completes normally.

Source files
------------

// File: rtl/ceres_pbus_bridge.sv
// CPU iomem to APB-style peripheral bus bridge: one outstanding transfer, slot = addr[15:12].
// Optional ACCESS timeout is enabled by defining CERES_PBUS_TIMEOUT_EN.
module ceres_pbus_bridge #(
  parameter int NUM_SLAVES     = 8,
  parameter int PADDR_W        = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  input  logic                    req_sel_i,
  input  logic [31:0]             req_addr_i,
  input  logic [31:0]             req_wdata_i,
  input  logic [3:0]              req_wstrb_i,
  output logic                    res_valid_o,
  output logic [31:0]             res_rdata_o,
  output logic                    res_err_o,
  output logic                    busy_o,
  output logic [NUM_SLAVES-1:0]   psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [PADDR_W-1:0]      paddr_o,
  output logic [31:0]             pwdata_o,
  output logic [3:0]              pstrb_o,
  input  logic [NUM_SLAVES*32-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]   pready_i,
  input  logic [NUM_SLAVES-1:0]   pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state;
  logic                    slot_ok;
  logic [NUM_SLAVES-1:0]   slot_onehot;
  logic                    sel_ready;
  logic                    sel_err;
  logic [31:0]             sel_rdata;
  logic                    addr_unused;

  assign slot_ok     = ({28'd0, req_addr_i[15:12]} < NUM_SLAVES);
  assign slot_onehot = NUM_SLAVES'(1) << req_addr_i[15:12];
  assign addr_unused = ^{req_addr_i[31:16], req_addr_i[1:0]};
  assign busy_o      = (state != IDLE);

  // psel_o is one-hot while a slave is addressed, so masking by it picks that slave
  assign sel_ready = |(pready_i & psel_o);
  assign sel_err   = |(pslverr_i & psel_o);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_o[i]) sel_rdata = sel_rdata | prdata_i[32*i +: 32];
    end
  end

`ifdef CERES_PBUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      psel_o      <= '0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      pstrb_o     <= '0;
      res_valid_o <= 1'b0;
      res_rdata_o <= '0;
      res_err_o   <= 1'b0;
`ifdef CERES_PBUS_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_sel_i) begin
            paddr_o  <= {req_addr_i[PADDR_W-1:2], 2'b00};
            pwdata_o <= req_wdata_i;
            pstrb_o  <= req_wstrb_i;
            pwrite_o <= |req_wstrb_i;
            if (slot_ok) begin
              psel_o <= slot_onehot;
              state  <= SETUP;
            end else begin
              res_valid_o <= 1'b1;
              res_err_o   <= 1'b1;
              res_rdata_o <= '0;
              state       <= RESP;
            end
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
`ifdef CERES_PBUS_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
          state     <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            psel_o      <= '0;
            penable_o   <= 1'b0;
            res_valid_o <= 1'b1;
            res_err_o   <= sel_err;
            res_rdata_o <= pwrite_o ? 32'd0 : sel_rdata;
            state       <= RESP;
`ifdef CERES_PBUS_TIMEOUT_EN
          // this cycle is the TIMEOUT_CYCLES-th one without pready
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            psel_o      <= '0;
            penable_o   <= 1'b0;
            res_valid_o <= 1'b1;
            res_err_o   <= 1'b1;
            res_rdata_o <= '0;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          res_valid_o <= 1'b0;
          res_err_o   <= 1'b0;
          res_rdata_o <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ceres_pbus_bridge.sv
// Randomized bench for ceres_pbus_bridge: a transaction-level model predicts every output each cycle.
module tb_ceres_pbus_bridge;
  localparam int NS = 8;
  localparam int PW = 12;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_sel;
  logic [31:0]       req_addr, req_wdata;
  logic [3:0]        req_wstrb;
  logic              res_valid, res_err, busy, penable, pwrite;
  logic [31:0]       res_rdata, pwdata;
  logic [NS-1:0]     psel, pready, pslverr;
  logic [PW-1:0]     paddr;
  logic [3:0]        pstrb;
  logic [NS*32-1:0]  prdata;

  always #5 clk = ~clk;

  ceres_pbus_bridge #(.NUM_SLAVES(NS), .PADDR_W(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_sel_i(req_sel),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .res_valid_o(res_valid), .res_rdata_o(res_rdata), .res_err_o(res_err), .busy_o(busy),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected outputs for the current cycle
  bit            chk_en = 1'b0;
  int            cur_rel;
  logic          exp_valid, exp_busy, exp_pen, exp_err, exp_pwrite;
  logic [NS-1:0] exp_psel;
  logic [31:0]   exp_rdata, exp_pwdata;
  logic [PW-1:0] exp_paddr;
  logic [3:0]    exp_pstrb;

  // observations of the last transaction, for literal checks
  int            cap_n, cap_rel;
  logic [31:0]   cap_rdata;
  logic          cap_err, cap_pwrite;
  logic [NS-1:0] cap_psel;
  logic [PW-1:0] cap_paddr;
  logic [3:0]    cap_pstrb;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("res_valid", 64'(res_valid), 64'(exp_valid));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("psel", 64'(psel), 64'(exp_psel));
      chk("penable", 64'(penable), 64'(exp_pen));
      if (exp_valid) begin
        chk("res_rdata", 64'(res_rdata), 64'(exp_rdata));
        chk("res_err", 64'(res_err), 64'(exp_err));
      end
      if (exp_psel != '0) begin
        chk("pwrite", 64'(pwrite), 64'(exp_pwrite));
        chk("paddr", 64'(paddr), 64'(exp_paddr));
        chk("pwdata", 64'(pwdata), 64'(exp_pwdata));
        chk("pstrb", 64'(pstrb), 64'(exp_pstrb));
      end
      if (res_valid) begin
        cap_n++;
        cap_rel   = cur_rel;
        cap_rdata = res_rdata;
        cap_err   = res_err;
      end
      if (psel != '0) begin
        cap_psel   = psel;
        cap_paddr  = paddr;
        cap_pwrite = pwrite;
        cap_pstrb  = pstrb;
      end
    end
  end

  task automatic randomize_slaves();
    pready  = NS'($urandom);
    pslverr = NS'($urandom);
    for (int i = 0; i < NS; i++) prdata[i*32 +: 32] = $urandom;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_sel   = req_valid ? 1'b0 : 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      randomize_slaves();
      exp_valid = 1'b0; exp_busy = 1'b0; exp_psel = '0; exp_pen = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // One transfer from the requester's view; rel 0 is the cycle the request is presented.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                     input int w, input logic serr, input logic [31:0] rd, input int abort_at);
    logic [3:0]    slot;
    logic [NS-1:0] oh;
    bit            ok, tmo;
    int            acc_end, r, hit;
    slot = addr[15:12];
    ok   = (slot < NS);
    oh   = NS'(1) << slot;
`ifdef CERES_PBUS_TIMEOUT_EN
    tmo = ok && (w >= TO);
`else
    tmo = 1'b0;
`endif
    hit     = tmo ? -1 : 2 + w;
    acc_end = tmo ? 1 + TO : 2 + w;
    r       = ok ? acc_end + 1 : 1;
    cap_n = 0; cap_rel = -1; cap_psel = '0; cap_rdata = '1; cap_err = 1'bx;
    for (int rel = 0; rel <= r; rel++) begin
      cur_rel   = rel;
      req_valid = 1'b1; req_sel = 1'b1;
      req_addr  = addr; req_wdata = wd; req_wstrb = ws;
      randomize_slaves();
      for (int i = 0; i < NS; i++) begin
        if (ok && i == int'(slot) && rel >= 2 && rel <= acc_end) pready[i] = (rel == hit);
        if (ok && i == int'(slot) && rel == hit) begin
          pslverr[i] = serr;
          prdata[i*32 +: 32] = rd;
        end
      end
      exp_valid  = (rel == r);
      exp_busy   = (rel >= 1);
      exp_psel   = (ok && rel >= 1 && rel <= acc_end) ? oh : '0;
      exp_pen    = ok && rel >= 2 && rel <= acc_end;
      exp_rdata  = (!ok || tmo || ws != 4'd0) ? 32'd0 : rd;
      exp_err    = !ok || tmo || serr;
      exp_pwrite = (ws != 4'd0);
      exp_paddr  = {addr[PW-1:2], 2'b00};
      exp_pwdata = wd;
      exp_pstrb  = ws;
      rst = (rel == abort_at);
      @(posedge clk); #1;
      if (rel == abort_at) begin
        rst = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    randomize_slaves();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_rdata", 64'(res_rdata), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_pstrb", 64'(pstrb), 64'd0);
    rst = 1'b0;
    exp_valid = 1'b0; exp_busy = 1'b0; exp_psel = '0; exp_pen = 1'b0;
    chk_en = 1'b1;
    idle(2);

    txn(32'h2000_1004, 32'h0, 4'h0, 0, 1'b0, 32'hA5A5_0001, -1);
    chk("t1_psel", 64'(cap_psel), 64'h2);
    chk("t1_paddr", 64'(cap_paddr), 64'h004);
    chk("t1_rel", 64'(cap_rel), 64'd3);
    chk("t1_rdata", 64'(cap_rdata), 64'hA5A5_0001);
    chk("t1_err", 64'(cap_err), 64'd0);
    idle(1);

    txn(32'h2000_0000, 32'h55, 4'h1, 2, 1'b0, 32'hDEAD_BEEF, -1);
    chk("t2_pwrite", 64'(cap_pwrite), 64'd1);
    chk("t2_pstrb", 64'(cap_pstrb), 64'h1);
    chk("t2_rel", 64'(cap_rel), 64'd5);
    chk("t2_rdata", 64'(cap_rdata), 64'd0);
    chk("t2_err", 64'(cap_err), 64'd0);
    idle(1);

    txn(32'h2000_9000, 32'h1234, 4'hF, 0, 1'b0, 32'h0, -1);
    chk("t3_psel", 64'(cap_psel), 64'd0);
    chk("t3_rel", 64'(cap_rel), 64'd1);
    chk("t3_err", 64'(cap_err), 64'd1);
    chk("t3_rdata", 64'(cap_rdata), 64'd0);
    idle(1);

    txn(32'h2000_2010, 32'h0, 4'h0, 1, 1'b1, 32'h1111_2222, -1);
    chk("t4_err", 64'(cap_err), 64'd1);
    chk("t4_pulses", 64'(cap_n), 64'd1);
    idle(1);

`ifdef CERES_PBUS_TIMEOUT_EN
    txn(32'h2000_3000, 32'h0, 4'h0, 10, 1'b0, 32'h0, -1);
    chk("t5_rel", 64'(cap_rel), 64'd6);
    chk("t5_err", 64'(cap_err), 64'd1);
`else
    txn(32'h2000_3000, 32'h0, 4'h0, 20, 1'b0, 32'h7777_0000, -1);
    chk("t5_rel", 64'(cap_rel), 64'd23);
    chk("t5_err", 64'(cap_err), 64'd0);
`endif
    idle(1);

    txn(32'h2000_4008, 32'h0, 4'h0, 5, 1'b0, 32'h0, 3);
    idle(1);
    chk("t6_abort_pulses", 64'(cap_n), 64'd0);
    txn(32'h2000_4008, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_0004, -1);
    chk("t6_after_pulses", 64'(cap_n), 64'd1);
    chk("t6_after_rdata", 64'(cap_rdata), 64'hCAFE_0004);
    idle(1);

    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      int          w;
      a = 32'h2000_0000 | ({28'd0, 4'($urandom_range(0, 9))} << 12) | {20'd0, 12'($urandom)};
      w = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 3);
      txn(a, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, w,
          1'($urandom_range(0, 1)), $urandom, -1);
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
